// File: rtl/mem_sweep_ctrl.sv
// Write/verify sweep sequencer for a single-port synchronous RAM, paced by an
// internal prescaler so the sweep is slow enough to watch on LEDs.
module mem_sweep_ctrl #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned TICK_DIV = 10_000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [DATA_W-1:0] pattern_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              step_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] err_addr_o
);

  localparam int unsigned    CntW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StCheck, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   pat_q;
  logic                err_q;
  logic [ADDR_W-1:0]   err_addr_q;

  logic                busy;
  logic                tick;
  logic                start_ok;
  logic                last_addr;
  logic [DATA_W-1:0]   exp_word;

  assign busy      = (state_q == StWrite) || (state_q == StRead) || (state_q == StCheck);
  assign tick      = busy && (cnt_q == CntMax);
  assign start_ok  = start_i && ((state_q == StIdle) || (state_q == StDone));
  assign last_addr = (addr_q == {ADDR_W{1'b1}});
  assign exp_word  = pat_q ^ DATA_W'(addr_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start_i) state_d = mode_i ? StRead : StWrite;
      StWrite:        if (tick && last_addr) state_d = StRead;
      StRead:         if (tick) state_d = StCheck;
      StCheck:        state_d = last_addr ? StDone : StRead;
      default:        state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      addr_q     <= '0;
      pat_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (start_ok) begin
      cnt_q      <= '0;
      addr_q     <= '0;
      pat_q      <= pattern_i;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      if (busy) cnt_q <= tick ? '0 : cnt_q + CntW'(1);
      // Address advances after each write and after each compare; wraps to 0 naturally.
      if ((state_q == StWrite && tick) || state_q == StCheck) addr_q <= addr_q + ADDR_W'(1);
      if (state_q == StCheck && mem_rdata_i != exp_word && !err_q) begin
        err_q      <= 1'b1;
        err_addr_q <= addr_q;
      end
    end
  end

  always_comb begin
    mem_we_o    = (state_q == StWrite) && tick;
    mem_wdata_o = (state_q == StWrite) ? exp_word : '0;
    mem_addr_o  = addr_q;
    step_o      = tick;
    busy_o      = busy;
    done_o      = (state_q == StDone);
    err_o       = err_q;
    err_addr_o  = err_addr_q;
  end

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// Directed bench for mem_sweep_ctrl: scoreboarded writes, read-back errors,
// ignored starts, mid-sweep reset and prescaler spacing at TICK_DIV 4 and 2.
module tb_mem_sweep_ctrl;
  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned TD_A = 4;
  localparam int unsigned TD_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_a, mode_a, start_b, mode_b;
  logic [DW-1:0] pat_a, pat_b;
  logic we_a, we_b, step_a, step_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [AW-1:0] addr_a, addr_b, eaddr_a, eaddr_b;
  logic [DW-1:0] wdata_a, wdata_b, rdata_a, rdata_b;

  logic [DW-1:0] ram_a [16];
  logic [DW-1:0] ram_b [16];
  logic clr_ram, corrupt;

  mem_sweep_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TICK_DIV(TD_A)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .mode_i(mode_a), .pattern_i(pat_a),
    .mem_we_o(we_a), .mem_addr_o(addr_a), .mem_wdata_o(wdata_a), .mem_rdata_i(rdata_a),
    .step_o(step_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a), .err_addr_o(eaddr_a)
  );

  mem_sweep_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TICK_DIV(TD_B)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .mode_i(mode_b), .pattern_i(pat_b),
    .mem_we_o(we_b), .mem_addr_o(addr_b), .mem_wdata_o(wdata_b), .mem_rdata_i(rdata_b),
    .step_o(step_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b), .err_addr_o(eaddr_b)
  );

  // RAM models; ram_a can corrupt reads of addresses 5 and 9
  always @(posedge clk) begin
    if (clr_ram) begin
      for (int i = 0; i < 16; i++) ram_a[i] <= '0;
    end else if (we_a) begin
      ram_a[addr_a] <= wdata_a;
    end
    rdata_a <= ram_a[addr_a] ^ ((corrupt && (addr_a == 4'd5 || addr_a == 4'd9)) ? 8'h5A : 8'h00);
    if (we_b) ram_b[addr_b] <= wdata_b;
    rdata_b <= ram_b[addr_b];
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int steps_a = 0, steps_b = 0, wes_a = 0;
  int last_step_a = -1, last_step_b = -1;
  logic prev_busy_a = 1'b0;
  logic [AW+DW-1:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic monitor();
    logic [AW+DW-1:0] e;
    chk("step_idle_a", {31'b0, step_a & ~busy_a}, 32'd0);
    chk("step_idle_b", {31'b0, step_b & ~busy_b}, 32'd0);
    if (step_a) begin
      steps_a++;
      if (last_step_a >= 0) chk("step_gap_a", cyc - last_step_a, TD_A);
      last_step_a = cyc;
    end
    if (!busy_a) last_step_a = -1;
    if (step_b) begin
      steps_b++;
      if (last_step_b >= 0) chk("step_gap_b", cyc - last_step_b, TD_B);
      last_step_b = cyc;
    end
    if (!busy_b) last_step_b = -1;
    if (we_a) begin
      wes_a++;
      chk("we_on_step", step_a, 1);
      chk("sb_nonempty_on_we", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_addr", addr_a, e[11:8]);
        chk("wr_data", wdata_a, e[7:0]);
      end
    end
  endtask

  task automatic step_clk();
    prev_busy_a = busy_a;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  task automatic chk_outs_zero(input string tag);
    chk(tag, {we_a, addr_a, wdata_a, step_a, busy_a, done_a, err_a, eaddr_a}, 32'd0);
  endtask

  task automatic run_sweep(input logic m, input logic [7:0] p, input int mid_tick,
                           input int rst_write, input logic exp_err, input logic [3:0] exp_ea);
    int lat;
    int s0;
    int w0;
    bit injected;
    bit aborted;
    mode_a  = m;
    pat_a   = p;
    start_a = 1'b1;
    if (!m) for (int a = 0; a < 16; a++) sb.push_back({4'(a), p ^ 8'(a)});
    s0 = steps_a;
    w0 = wes_a;
    step_clk();
    start_a = 1'b0;
    chk("busy_on_start", busy_a, 1);
    chk("done_clr", done_a, 0);
    chk("err_clr", err_a, 0);
    chk("eaddr_clr", eaddr_a, 0);
    chk("addr_start", addr_a, 0);
    lat = 0;
    injected = 0;
    aborted = 0;
    while (!done_a && lat < 2000 && !aborted) begin
      step_clk();
      lat++;
      start_a = 1'b0;
      if (mid_tick > 0 && !injected && steps_a - s0 == mid_tick) begin
        start_a  = 1'b1;
        mode_a   = 1'b1;
        pat_a    = ~p;
        injected = 1;
      end
      if (rst_write > 0 && wes_a - w0 == rst_write) begin
        rst_n = 1'b0;
        #1;
        chk_outs_zero("rst_mid_sweep");
        sb.delete();
        aborted = 1;
      end
    end
    start_a = 1'b0;
    mode_a  = 1'b0;
    pat_a   = '0;
    if (aborted) begin
      step_clk();
      chk_outs_zero("rst_held");
      rst_n = 1'b1;
      step_clk();
      chk_outs_zero("idle_after_rst");
    end else begin
      chk("done_latency", lat, (m ? 16 : 32) * TD_A + 1);
      chk("tick_count", steps_a - s0, m ? 16 : 32);
      chk("we_count", wes_a - w0, m ? 0 : 16);
      chk("sb_drained", sb.size(), 0);
      chk("busy_fall", {busy_a, prev_busy_a}, 2'b10 >> 1);
      chk("err_end", err_a, exp_err);
      chk("eaddr_end", eaddr_a, exp_ea);
      chk("addr_wrap", addr_a, 0);
      step_clk();
      chk("done_hold", {done_a, busy_a, err_a, eaddr_a}, {1'b1, 1'b0, exp_err, exp_ea});
    end
  endtask

  initial begin
    int lat_b;
    rst_n   = 1'b0;
    clr_ram = 1'b1;
    corrupt = 1'b0;
    start_a = 1'b0; mode_a = 1'b0; pat_a = '0;
    start_b = 1'b0; mode_b = 1'b0; pat_b = '0;
    #1;
    chk_outs_zero("reset_a");
    chk("reset_b", {we_b, addr_b, wdata_b, step_b, busy_b, done_b, err_b, eaddr_b}, 32'd0);
    step_clk();
    step_clk();
    rst_n   = 1'b1;
    clr_ram = 1'b0;
    step_clk();
    chk_outs_zero("idle_a");

    // Ideal RAM, write then verify
    run_sweep(1'b0, 8'hA5, 0, 0, 1'b0, 4'd0);
    chk("ram_a3", ram_a[3], 8'hA6);

    // Corrupted reads at 5 and 9, first failing address reported
    corrupt = 1'b1;
    run_sweep(1'b0, 8'hA5, 0, 0, 1'b1, 4'd5);
    corrupt = 1'b0;

    // Verify-only on a cleared RAM
    clr_ram = 1'b1;
    step_clk();
    clr_ram = 1'b0;
    run_sweep(1'b1, 8'h00, 0, 0, 1'b1, 4'd1);

    // Start pulse at tick 7 must be ignored
    run_sweep(1'b0, 8'h3C, 7, 0, 1'b0, 4'd0);

    // Reset at the 5th write, then a full sweep
    run_sweep(1'b0, 8'h5A, 0, 5, 1'b0, 4'd0);
    run_sweep(1'b0, 8'h5A, 0, 0, 1'b0, 4'd0);
    chk("ram_a0", ram_a[0], 8'h5A);

    // TICK_DIV=2 instance
    mode_b  = 1'b0;
    pat_b   = 8'h11;
    start_b = 1'b1;
    step_clk();
    start_b = 1'b0;
    pat_b   = '0;
    chk("busy_b_start", busy_b, 1);
    lat_b = 0;
    while (!done_b && lat_b < 2000) begin
      step_clk();
      lat_b++;
    end
    chk("done_latency_b", lat_b, 32 * TD_B + 1);
    chk("tick_count_b", steps_b, 32);
    chk("err_b", err_b, 0);
    chk("ram_b3", ram_b[3], 8'h12);
    step_clk();
    step_clk();
    chk("step_b_silent", steps_b, 32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_sweep_ctrl.md
Name: mem_sweep_ctrl

Overview:
- Sequencer for the MemoriaRAM datapath: steps a single-port synchronous RAM through a timed write sweep and then a read-back/verify sweep.
- Pacing comes from an internal prescaler that produces a one-cycle step enable on the system clock. No derived clock is used, so a human can watch the sweep on LEDs/displays.
- Sits between the board-level buttons/switches and the RAM instance. Reports busy, done, a sticky error flag and the first failing address.

Parameters:
- ADDR_W, 4, RAM address width; sweep covers 2^ADDR_W words.
- DATA_W, 8, RAM data width; must be >= ADDR_W.
- TICK_DIV, 10_000, clk_i cycles per sweep step; legal range >= 2.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset
- start_i  in  1  one-cycle start request
- mode_i  in  1  0 = write then verify, 1 = verify only; sampled with start
- pattern_i  in  DATA_W  base pattern; sampled with start
- mem_we_o  out  1  RAM write enable, one-cycle pulse
- mem_addr_o  out  ADDR_W  RAM address
- mem_wdata_o  out  DATA_W  RAM write data
- mem_rdata_i  in  DATA_W  RAM read data, valid 1 cycle after address
- step_o  out  1  one-cycle pulse per prescaler tick while busy
- busy_o  out  1  sweep in progress
- done_o  out  1  level; sweep finished, held until next accepted start
- err_o  out  1  sticky mismatch flag
- err_addr_o  out  ADDR_W  address of first mismatch

Interface (already decided): one clock; reset is asynchronous and active-low (clk_i, rst_ni).

Behaviour:
- Reset (rst_ni=0, async): state IDLE. All outputs 0, including mem_addr_o, mem_wdata_o, err_addr_o. Prescaler and latched pattern/mode are 0.
- Expected word: exp(a) = pat ^ zero-extend(a), truncated to DATA_W. pat is the latched pattern_i.
- Prescaler: counts 0..TICK_DIV-1 only while busy_o=1. tick = (cnt==TICK_DIV-1), then cnt wraps to 0. step_o = tick. cnt is forced to 0 on an accepted start.
- Start acceptance: start_i is accepted in IDLE or DONE only; ignored while busy_o=1. Accepting start:
  - latches mode_i and pattern_i;
  - clears err_o, err_addr_o and done_o, and sets mem_addr_o=0;
  - moves to WRITE (mode 0) or READ (mode 1);
  - sets busy_o=1 on the next cycle.
- WRITE: on each tick, mem_we_o=1 for exactly that cycle, with mem_wdata_o=exp(mem_addr_o).
  - The cycle after the write, the address increments.
  - The write to address 2^ADDR_W-1 wraps the address to 0 and moves to READ.
  - First write occurs TICK_DIV cycles after start.
- READ: mem_we_o=0. On each tick the current address is already presented; move to CHECK.
- CHECK (1 cycle): compare mem_rdata_i with exp(addr).
  - On mismatch with err_o=0: set err_o=1 and err_addr_o=addr. Later mismatches leave err_addr_o unchanged.
  - Then if addr is the last address: go to DONE and wrap addr to 0. Otherwise increment addr and return to READ.
- DONE: busy_o=0, done_o=1, prescaler halted. mem_addr_o, err_o and err_addr_o hold.
- Total sweep length:
  - mode 0: 2*2^ADDR_W ticks;
  - mode 1: 2^ADDR_W ticks.
- Reset mid-sweep: immediate return to reset values. The RAM contents are not touched; no further write pulse is issued.
- mem_wdata_o is driven only in WRITE; it is 0 otherwise.

Test Plan:
- TICK_DIV=4, ADDR_W=4, DATA_W=8, mode 0, pattern 8'hA5, ideal RAM model:
  - 16 writes, we pulses spaced 4 cycles apart;
  - addr 3 written with 8'hA6;
  - done_o=1 after 32 ticks, err_o=0, busy_o falling with done_o rising.
- Same setup, RAM model corrupts addr 5 and addr 9 on read -> err_o=1, err_addr_o=5, done_o=1 at the end.
- Mode 1 on an unwritten (all-zero) RAM, pattern 8'h00 -> zero we pulses; mismatch at addr 1 (exp 8'h01) gives err_addr_o=1; 16 ticks to done.
- start_i pulsed at tick 7 during a sweep -> ignored; sequence and timing unchanged. start in DONE -> err/done cleared and a new sweep begins.
- rst_ni low for 1 cycle at the 5th write -> all outputs 0 immediately, IDLE. A subsequent start runs a full sweep from addr 0.
- Check step_o pulses exactly every TICK_DIV cycles while busy and is silent in IDLE/DONE. Repeat with TICK_DIV=2 as a boundary case.
